// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) built on a
//            radix-2 restoring algorithm, one quotient bit per cycle. Sits
//            beside EX and owns a register-file write port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   start_i      in   launch request, sampled only in IDLE
//   op_i         in   00=DIV 01=DIVU 10=REM 11=REMU
//   dividend_i   in   rs1 value
//   divisor_i    in   rs2 value
//   rd_i         in   destination register address
//   kill_i       in   pipeline flush, aborts the current operation
//   busy_o       out  high whenever the unit is not IDLE
//   ready_o      out  one-cycle pulse in DONE unless killed
//   reg_we_o     out  register write enable (never for x0)
//   reg_waddr_o  out  register write address
//   reg_wdata_o  out  register write data (quotient or remainder)
// ============================================================================
module div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  // Launch-time operand decode
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div_zero;
  logic            w_ovf;

  assign w_signed   = ~op_i[0];
  assign w_a_neg    = w_signed & dividend_i[XLEN-1];
  assign w_b_neg    = w_signed & divisor_i[XLEN-1];
  assign w_a_abs    = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_b_abs    = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_signed & (dividend_i == C_MIN_NEG) & (divisor_i == '1);

  // One restoring step: the shifted partial remainder is XLEN+1 bits wide so
  // the borrow of the trial subtract is the comparison result.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_shift   = {rem_q, quo_q[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, dvs_q};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {quo_q[XLEN-2:0], w_ge};
  assign w_quo_fix = neg_quo_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fix = neg_rem_q ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_q      <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rd_q      <= rd_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rd_d      = rd_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        // A flush in the launch cycle wins over the start request.
        if (start_i && !kill_i) begin
          is_rem_d  = op_i[1];
          rd_d      = rd_i;
          neg_quo_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          if (w_div_zero) begin
            wdata_d = op_i[1] ? dividend_i : '1;
            waddr_d = rd_i;
            state_d = S_DONE;
          end else if (w_ovf) begin
            wdata_d = op_i[1] ? '0 : C_MIN_NEG;
            waddr_d = rd_i;
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = w_a_abs;
            dvs_d   = w_b_abs;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_rem_nxt;
          quo_d = w_quo_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            // Sign fix-up is folded into the final iteration so the result
            // register is already correct in the DONE cycle.
            wdata_d = is_rem_q ? w_rem_fix : w_quo_fix;
            waddr_d = rd_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign ready_o     = (state_q == S_DONE) && !kill_i;
  assign reg_we_o    = (state_q == S_DONE) && !kill_i && (rd_q != 5'd0);
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: vector table of divisions
//            plus hand-written kill, reset and back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        kill_i;
  logic        busy_o;
  logic        ready_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // {we, waddr, wdata} expected at each ready_o pulse
  logic [37:0] sb_q[$];

  div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .rd_i        (rd_i),
    .kill_i      (kill_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every result cycle pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 32'(ready_o), 32'd0);
        end else begin
          logic [37:0] e;
          e = sb_q.pop_front();
          check("wdata", reg_wdata_o, e[31:0]);
          check("waddr", 32'(reg_waddr_o), 32'(e[36:32]));
          check("we", 32'(reg_we_o), 32'(e[37]));
        end
      end else if (reg_we_o) begin
        check("we_without_ready", 32'(reg_we_o), 32'd0);
      end
    end
  end

  // Launch one op and wait for ready; returns with the DONE cycle finished
  // at its negedge. Checks latency and that busy is high throughout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int k;
    bit busy_ok;
    sb_q.push_back({(rd != 5'd0), rd, exp});
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_i = rd;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (!busy_o) busy_ok = 1'b0;
      if (ready_o || k >= 80) break;
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("busy_during_op", 32'(busy_ok), 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          5'd5,  32'd2,          33};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          5'd6,  32'hFFFFFFFD,   33};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFF,   33};
    vecs[4]  = '{DIV,  32'd7,          32'hFFFFFFFE,   5'd8,  32'hFFFFFFFD,   33};
    vecs[5]  = '{REM,  32'd7,          32'hFFFFFFFE,   5'd9,  32'd1,          33};
    vecs[6]  = '{DIV,  32'd1234,       32'd0,          5'd10, 32'hFFFFFFFF,   1};
    vecs[7]  = '{REMU, 32'd1234,       32'd0,          5'd11, 32'd1234,       1};
    vecs[8]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   5'd12, 32'h80000000,   1};
    vecs[9]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   5'd13, 32'd0,          1};
    vecs[10] = '{DIV,  32'h80000000,   32'd3,          5'd14, 32'hD5555556,   33};
    vecs[11] = '{REM,  32'h80000000,   32'd3,          5'd15, 32'hFFFFFFFE,   33};
    vecs[12] = '{DIVU, 32'hFFFFFFFF,   32'd1,          5'd16, 32'hFFFFFFFF,   33};
    vecs[13] = '{REMU, 32'hFFFFFFFF,   32'h10,         5'd17, 32'hF,          33};
    vecs[14] = '{DIVU, 32'd3,          32'd10,         5'd31, 32'd0,          33};

    rst_n = 1'b0; start_i = 1'b0; op_i = 2'b00; dividend_i = '0;
    divisor_i = '0; rd_i = '0; kill_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_we", 32'(reg_we_o), 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);
    end

    // Outside DONE the write port is quiet but address/data hold.
    @(negedge clk);
    check("hold_wdata", reg_wdata_o, 32'd0);
    check("hold_waddr", 32'(reg_waddr_o), 32'd31);

    // Kill mid-CALC, with an ignored second start while busy.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = DIVU; dividend_i = 32'd500; divisor_i = 32'd5; rd_i = 5'd3;
    @(posedge clk); #1;                         // cycle N+1
    start_i = 1'b0;
    repeat (4) @(posedge clk); #1;              // cycle N+5
    start_i = 1'b1; dividend_i = 32'd77; divisor_i = 32'd7; rd_i = 5'd4;
    @(posedge clk); #1;                         // N+6
    start_i = 1'b0;
    repeat (4) @(posedge clk); #1;              // N+10
    kill_i = 1'b1;
    @(negedge clk);
    check("busy_before_kill_edge", 32'(busy_o), 32'd1);
    @(posedge clk); #1;                         // N+11
    kill_i = 1'b0;
    @(negedge clk);
    check("idle_after_kill", 32'(busy_o), 32'd0);
    repeat (40) @(negedge clk);
    check("still_idle_after_kill", 32'(busy_o), 32'd0);

    // Kill together with start in IDLE: nothing launches.
    @(posedge clk); #1;
    start_i = 1'b1; kill_i = 1'b1; op_i = DIVU; dividend_i = 32'd9; divisor_i = 32'd3; rd_i = 5'd2;
    @(posedge clk); #1;
    start_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    check("kill_beats_start", 32'(busy_o), 32'd0);

    // x0 destination, then back-to-back launch in the cycle after DONE.
    run_op(DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 33);
    run_op(DIVU, 32'd45, 32'd6, 5'd20, 32'd7, 33);

    // Reset mid-operation abandons it and clears the result registers.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = REMU; dividend_i = 32'd50; divisor_i = 32'd7; rd_i = 5'd21;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_wdata", reg_wdata_o, 32'd0);
    check("midreset_waddr", 32'(reg_waddr_o), 32'd0);
    repeat (40) @(negedge clk);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) using a radix-2 restoring algorithm.
- Sits beside EX: launched by decode/EX, it drives its own general-register-file write port triple (we/waddr/wdata) when the result is ready.
- Exposes busy so the ID stage can stall dependent and structurally conflicting instructions.

Parameters:
- XLEN, 32, operand/result width; the iteration counter is $clog2(XLEN) bits.
- ITER, XLEN, iteration count (fixed, equal to XLEN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  launch request, sampled only in IDLE
- op_i  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- dividend_i  in  XLEN  rs1 value
- divisor_i  in  XLEN  rs2 value
- rd_i  in  5  destination register address
- kill_i  in  1  pipeline flush; abort the current operation
- busy_o  out  1  high whenever state != IDLE
- ready_o  out  1  one-cycle pulse in DONE, unless killed
- reg_we_o  out  1  register write enable, to the register-file write port
- reg_waddr_o  out  5  register write address
- reg_wdata_o  out  XLEN  register write data (quotient or remainder)

Behaviour:
- Reset (rst_n=0 at posedge) forces state=IDLE and clears all internal registers. Reset values:
  - busy_o=0, ready_o=0, reg_we_o=0
  - reg_waddr_o=0, reg_wdata_o=0
- Reset mid-operation abandons the operation; no write is issued.
- States: IDLE, CALC, DONE.
- IDLE, when start_i=1 at cycle N:
  - latch op, rd, and the operand signs.
  - Signed ops take the absolute value of each operand.
  - If divisor=0, or a signed op has dividend=0x80000000 with divisor=0xFFFFFFFF, go directly to DONE with a preset result.
  - Otherwise go to CALC with count=0, remainder accumulator=0, quotient shift register=|dividend|.
- Special-case results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give dividend_i unchanged.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- CALC, one iteration per cycle:
  - shift {rem,quo} left by 1.
  - If rem >= |divisor|, subtract |divisor| and set quo[0]=1.
  - Use an XLEN+1-bit subtract.
  - After iteration ITER-1 (count wraps from 31), go to DONE.
- Sign fix-up, applied when entering DONE:
  - quotient negated if the signs differ (DIV only).
  - remainder takes the dividend's sign (REM only).
- DONE lasts exactly 1 cycle, then returns to IDLE.
  - reg_wdata_o carries the result; reg_waddr_o=rd.
  - reg_we_o = (rd != 0) and not kill_i.
  - ready_o = not kill_i.
- Latency:
  - Normal operation: DONE/write in cycle N+33; busy_o high in cycles N+1..N+33.
  - Special cases: DONE in cycle N+1.
- Outside DONE: reg_we_o=0 and ready_o=0. reg_waddr_o and reg_wdata_o hold their last values.
- start_i while busy is ignored; it is not queued. The ID stage must hold the instruction until busy_o=0.
- start_i and DONE in the same cycle: start is ignored; the next launch is accepted in the following IDLE cycle.
- kill_i in CALC: return to IDLE at the next edge with no write.
- kill_i in IDLE with start_i: kill wins, and the operation is not launched.
- rd_i=0: the full operation runs and ready_o pulses, but reg_we_o stays 0 (x0 is never written).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> busy_o=0, reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0.
- DIVU 100/7, rd=5, start at N -> busy in N+1..N+33; in N+33 reg_we_o=1, waddr=5, wdata=14. Repeat with REMU -> wdata=2.
- Signed ops:
  - DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD (-3).
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - DIV 7/-2 -> 0xFFFFFFFD.
  - REM 7/-2 -> 1.
- Specials:
  - DIV 1234/0 -> 0xFFFFFFFF in N+1.
  - REMU 1234/0 -> 1234 in N+1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- kill_i at N+10 -> IDLE at N+11, no reg_we_o pulse. A second start_i asserted at N+5 (while busy) -> ignored, no extra write.
- rd=0, DIVU 9/3 -> ready_o pulses at N+33 with reg_we_o=0. Back-to-back launch at N+34 -> accepted, result at N+67.
